// File: rtl/ttt_referee_pkg.sv
// ttt_referee_pkg: marker codes, FSM states, move limit and winning-line table for the referee.
package ttt_referee_pkg;
  localparam int SCAN_LINES = 8;
  localparam logic [3:0] MAX_MOVES = 4'd9;
  localparam logic [2:0] BLANK = 3'd0;
  localparam logic [2:0] P1 = 3'd1;
  localparam logic [2:0] P2 = 3'd2;
  typedef enum logic [1:0] {WAIT_MOVE, SCAN, WIN, DRAW} state_t;
  // one nibble per square (1-based), three per line, line 0 in the low bits
  localparam logic [95:0] LINE_TABLE = 96'h753_951_963_852_741_987_654_321;
  function automatic logic [3:0] line_sq(input logic [2:0] idx, input logic [1:0] k);
    return LINE_TABLE[(int'(idx) * 3 + int'(k)) * 4 +: 4];
  endfunction
  function automatic logic [2:0] square_code(input logic [26:0] board, input logic [3:0] sq);
    return board[(int'(sq) - 1) * 3 +: 3];
  endfunction
endpackage

// File: rtl/ttt_referee_line_select.sv
// ttt_referee_line_select: picks the three squares of one winning line and flags a completed line.
module ttt_referee_line_select
  import ttt_referee_pkg::*;
(
  input  logic [2:0]  line_idx,
  input  logic [26:0] board,
  output logic [1:0]  mark,
  output logic        match
);
  logic [2:0] code_a, code_b, code_c;
  always_comb begin
    code_a = square_code(board, line_sq(line_idx, 2'd0));
    code_b = square_code(board, line_sq(line_idx, 2'd1));
    code_c = square_code(board, line_sq(line_idx, 2'd2));
    match = code_a != BLANK && code_a == code_b && code_b == code_c;
    mark = code_a[1:0];
  end
endmodule

// File: rtl/ttt_referee.sv
// ttt_referee: validates moves against a board snapshot, scans the winning lines one per cycle, tracks turn and result.
module ttt_referee
  import ttt_referee_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [26:0] board,
  output logic        player_turn,
  output logic        busy,
  output logic        illegal_move,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  win_line,
  output logic        draw,
  output logic [3:0]  move_count
);
  state_t state, state_n;
  logic [26:0] snapshot, snapshot_n;
  logic [2:0] line_idx, line_idx_n, win_line_n, want;
  logic [3:0] move_count_n, n_diff;
  logic [1:0] winner_n, mark;
  logic player_turn_n, busy_n, illegal_n, game_over_n, draw_n, match, sq_ok, legal;

  ttt_referee_line_select u_line (
    .line_idx(line_idx),
    .board(snapshot),
    .mark(mark),
    .match(match)
  );

  // a legal change touches exactly one square, blank -> current player's marker
  always_comb begin
    want = player_turn ? P2 : P1;
    n_diff = '0;
    sq_ok = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (board[i*3 +: 3] != snapshot[i*3 +: 3]) begin
        n_diff = n_diff + 4'd1;
        sq_ok = snapshot[i*3 +: 3] == BLANK && board[i*3 +: 3] == want;
      end
    end
    legal = n_diff == 4'd1 && sq_ok;
  end

  always_comb begin
    state_n = state;
    snapshot_n = snapshot;
    line_idx_n = line_idx;
    player_turn_n = player_turn;
    busy_n = busy;
    illegal_n = 1'b0;
    game_over_n = game_over;
    winner_n = winner;
    win_line_n = win_line;
    draw_n = draw;
    move_count_n = move_count;
    if (state == WAIT_MOVE && board != snapshot) begin
      snapshot_n = board;
      if (legal) begin
        move_count_n = move_count == MAX_MOVES ? move_count : move_count + 4'd1;
        line_idx_n = '0;
        busy_n = 1'b1;
        state_n = SCAN;
      end else begin
        illegal_n = 1'b1;
      end
    end
    if (state == SCAN) begin
      line_idx_n = line_idx + 3'd1;
      if (match) begin
        winner_n = mark;
        win_line_n = line_idx;
        game_over_n = 1'b1;
        busy_n = 1'b0;
        state_n = WIN;
      end else if (line_idx == 3'(SCAN_LINES - 1)) begin
        busy_n = 1'b0;
        draw_n = move_count == MAX_MOVES;
        game_over_n = move_count == MAX_MOVES;
        player_turn_n = move_count == MAX_MOVES ? player_turn : ~player_turn;
        state_n = move_count == MAX_MOVES ? DRAW : WAIT_MOVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= WAIT_MOVE;
      snapshot <= '0;
      line_idx <= '0;
      player_turn <= 1'b0;
      busy <= 1'b0;
      illegal_move <= 1'b0;
      game_over <= 1'b0;
      winner <= '0;
      win_line <= '0;
      draw <= 1'b0;
      move_count <= '0;
    end else begin
      state <= state_n;
      snapshot <= snapshot_n;
      line_idx <= line_idx_n;
      player_turn <= player_turn_n;
      busy <= busy_n;
      illegal_move <= illegal_n;
      game_over <= game_over_n;
      winner <= winner_n;
      win_line <= win_line_n;
      draw <= draw_n;
      move_count <= move_count_n;
    end
  end
endmodule

// File: tb/tb_ttt_referee.sv
// tb_ttt_referee: directed game scenarios plus random games checked against a board-level referee model.
module tb_ttt_referee;
  logic clk = 1'b0;
  logic clr;
  logic [26:0] board;
  logic player_turn, busy, illegal_move, game_over, draw;
  logic [1:0] winner;
  logic [2:0] win_line;
  logic [3:0] move_count;
  int checks = 0;
  int errors = 0;
  int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
  logic [26:0] m_snap;
  int m_turn, m_count, m_winner, m_line;
  bit m_over, m_draw;

  ttt_referee dut (
    .clk(clk), .clr(clr), .board(board), .player_turn(player_turn), .busy(busy),
    .illegal_move(illegal_move), .game_over(game_over), .winner(winner),
    .win_line(win_line), .draw(draw), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1'b1;
    board = '0;
    tick;
    clr = 1'b0;
    m_snap = '0;
    m_turn = 0;
    m_count = 0;
    m_winner = 0;
    m_line = 0;
    m_over = 0;
    m_draw = 0;
  endtask

  // drive a new board, update the referee model, and wait out any scan
  task automatic apply(input logic [26:0] nb, output bit ill);
    int diff, w;
    bit ok, scan;
    ill = 0;
    scan = 0;
    if (!m_over && nb !== m_snap) begin
      diff = 0;
      ok = 0;
      for (int i = 0; i < 9; i++)
        if (nb[i*3 +: 3] != m_snap[i*3 +: 3]) begin
          diff++;
          ok = m_snap[i*3 +: 3] == 3'd0 && nb[i*3 +: 3] == 3'(m_turn + 1);
        end
      m_snap = nb;
      if (diff == 1 && ok) begin
        scan = 1;
        if (m_count < 9) m_count++;
        w = -1;
        for (int l = 7; l >= 0; l--)
          if (m_snap[lines[l][0]*3 +: 3] != 0 && m_snap[lines[l][0]*3 +: 3] == m_snap[lines[l][1]*3 +: 3]
              && m_snap[lines[l][1]*3 +: 3] == m_snap[lines[l][2]*3 +: 3]) w = l;
        if (w >= 0) begin
          m_over = 1;
          m_winner = int'(m_snap[lines[w][0]*3 +: 3]);
          m_line = w;
        end else if (m_count == 9) begin
          m_over = 1;
          m_draw = 1;
        end else m_turn ^= 1;
      end else ill = 1;
    end
    board = nb;
    tick;
    if (scan) begin
      for (int c = 0; c < 12 && busy === 1'b1; c++) tick;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL scan_timeout busy=%b required 0", busy);
      end
    end
  endtask

  task automatic place(input int sq, input int mark, output bit ill);
    logic [26:0] nb;
    nb = board;
    nb[(sq-1)*3 +: 3] = 3'(mark);
    apply(nb, ill);
  endtask

  task automatic test_reset;
    do_reset;
    checks += 4;
    if ({busy, illegal_move, game_over, draw} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b required 0000", {busy, illegal_move, game_over, draw});
    end
    if (player_turn !== 1'b0) begin errors++; $display("FAIL reset_turn got %b required 0", player_turn); end
    if (move_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d required 0", move_count); end
    if ({winner, win_line} !== 5'd0) begin errors++; $display("FAIL reset_winner got %0d/%0d required 0/0", winner, win_line); end
  endtask

  task automatic test_legal_move;
    do_reset;
    board[14:12] = 3'd1;
    tick;
    checks += 2;
    if (move_count !== 4'd1) begin errors++; $display("FAIL legal_count got %0d required 1", move_count); end
    if (busy !== 1'b1) begin errors++; $display("FAIL legal_busy_e0 got %b required 1", busy); end
    for (int k = 1; k < 8; k++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || player_turn !== 1'b0) begin
        errors++; $display("FAIL legal_scan_e%0d busy=%b turn=%b required 1/0", k, busy, player_turn);
      end
    end
    tick;
    checks += 2;
    if (busy !== 1'b0 || player_turn !== 1'b1) begin
      errors++; $display("FAIL legal_e8 busy=%b turn=%b required 0/1", busy, player_turn);
    end
    if (winner !== 2'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL legal_no_win winner=%0d over=%b required 0/0", winner, game_over);
    end
  endtask

  task automatic test_row_win;
    int sqs [5] = '{1, 4, 2, 5, 3};
    bit ill;
    do_reset;
    foreach (sqs[i]) place(sqs[i], (i % 2) + 1, ill);
    checks += 3;
    if (winner !== 2'd1 || win_line !== 3'd0) begin
      errors++; $display("FAIL row_win winner=%0d line=%0d required 1/0", winner, win_line);
    end
    if (game_over !== 1'b1 || draw !== 1'b0) begin
      errors++; $display("FAIL row_over over=%b draw=%b required 1/0", game_over, draw);
    end
    if (move_count !== 4'd5) begin errors++; $display("FAIL row_count got %0d required 5", move_count); end
  endtask

  task automatic test_diag_win;
    int sqs [6] = '{1, 3, 2, 5, 4, 7};
    bit ill;
    do_reset;
    foreach (sqs[i]) place(sqs[i], (i % 2) + 1, ill);
    checks += 2;
    if (winner !== 2'd2 || win_line !== 3'd7) begin
      errors++; $display("FAIL diag_win winner=%0d line=%0d required 2/7", winner, win_line);
    end
    if (game_over !== 1'b1 || move_count !== 4'd6) begin
      errors++; $display("FAIL diag_over over=%b count=%0d required 1/6", game_over, move_count);
    end
  endtask

  task automatic test_draw;
    int sqs [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    bit ill;
    do_reset;
    foreach (sqs[i]) place(sqs[i], (i % 2) + 1, ill);
    checks += 3;
    if (draw !== 1'b1 || winner !== 2'd0) begin
      errors++; $display("FAIL draw_flag draw=%b winner=%0d required 1/0", draw, winner);
    end
    if (game_over !== 1'b1 || move_count !== 4'd9) begin
      errors++; $display("FAIL draw_over over=%b count=%0d required 1/9", game_over, move_count);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL draw_busy got %b required 0", busy); end
    place(1, 0, ill);
    checks++;
    if (illegal_move !== 1'b0 || game_over !== 1'b1) begin
      errors++; $display("FAIL draw_terminal illegal=%b over=%b required 0/1", illegal_move, game_over);
    end
  endtask

  task automatic test_illegal;
    logic [26:0] nb;
    bit ill;
    do_reset;
    place(2, 2, ill);
    checks += 2;
    if (illegal_move !== 1'b1) begin errors++; $display("FAIL ill_wrong_player got %b required 1", illegal_move); end
    if (move_count !== 4'd0 || player_turn !== 1'b0) begin
      errors++; $display("FAIL ill_wrong_state count=%0d turn=%b required 0/0", move_count, player_turn);
    end
    tick;
    checks++;
    if (illegal_move !== 1'b0) begin errors++; $display("FAIL ill_pulse_width got %b required 0", illegal_move); end
    nb = board;
    nb[2:0] = 3'd1;
    nb[5:3] = 3'd1;
    apply(nb, ill);
    checks++;
    if (illegal_move !== 1'b1 || move_count !== 4'd0) begin
      errors++; $display("FAIL ill_two_squares illegal=%b count=%0d required 1/0", illegal_move, move_count);
    end
    place(5, 1, ill);
    checks++;
    if (move_count !== 4'd1 || player_turn !== 1'b1 || illegal_move !== 1'b0) begin
      errors++; $display("FAIL ill_then_legal count=%0d turn=%b ill=%b required 1/1/0", move_count, player_turn, illegal_move);
    end
    place(5, 2, ill);
    checks++;
    if (illegal_move !== 1'b1 || move_count !== 4'd1 || player_turn !== 1'b1) begin
      errors++; $display("FAIL ill_overwrite ill=%b count=%0d turn=%b required 1/1/1", illegal_move, move_count, player_turn);
    end
  endtask

  task automatic test_clr_mid_scan;
    do_reset;
    board[14:12] = 3'd1;
    tick;
    tick;
    tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got %b required 1", busy); end
    clr = 1'b1;
    board = '0;
    tick;
    clr = 1'b0;
    checks += 2;
    if ({busy, illegal_move, game_over, draw, player_turn} !== 5'b0) begin
      errors++; $display("FAIL clr_flags got %b required 00000", {busy, illegal_move, game_over, draw, player_turn});
    end
    if (move_count !== 4'd0 || winner !== 2'd0) begin
      errors++; $display("FAIL clr_count count=%0d winner=%0d required 0/0", move_count, winner);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || move_count !== 4'd0) begin
      errors++; $display("FAIL clr_after busy=%b count=%0d required 0/0", busy, move_count);
    end
  endtask

  task automatic test_random_games;
    logic [26:0] nb;
    int blanks[$];
    bit ill;
    for (int g = 0; g < 30; g++) begin
      do_reset;
      for (int s = 0; s < 20 && !m_over; s++) begin
        nb = board;
        if ($urandom_range(0, 4) != 0) begin
          blanks.delete();
          for (int i = 0; i < 9; i++) if (board[i*3 +: 3] == 3'd0) blanks.push_back(i);
          if (blanks.size() == 0) break;
          nb[blanks[$urandom_range(0, blanks.size() - 1)]*3 +: 3] = 3'(m_turn + 1);
        end else begin
          nb[$urandom_range(0, 8)*3 +: 3] = 3'($urandom_range(0, 2));
          if ($urandom_range(0, 1) == 1) nb[$urandom_range(0, 8)*3 +: 3] = 3'($urandom_range(0, 2));
        end
        apply(nb, ill);
        checks += 4;
        if (illegal_move !== ill || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_illegal g%0d s%0d ill=%b busy=%b required %b/0", g, s, illegal_move, busy, ill);
        end
        if (move_count !== 4'(m_count) || player_turn !== 1'(m_turn)) begin
          errors++; $display("FAIL rnd_count g%0d s%0d count=%0d turn=%b required %0d/%0d", g, s, move_count, player_turn, m_count, m_turn);
        end
        if (game_over !== m_over || draw !== m_draw) begin
          errors++; $display("FAIL rnd_over g%0d s%0d over=%b draw=%b required %b/%b", g, s, game_over, draw, m_over, m_draw);
        end
        if (winner !== 2'(m_winner) || win_line !== 3'(m_line)) begin
          errors++; $display("FAIL rnd_winner g%0d s%0d winner=%0d line=%0d required %0d/%0d", g, s, winner, win_line, m_winner, m_line);
        end
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    board = '0;
    test_reset;
    test_legal_move;
    test_row_win;
    test_diag_win;
    test_draw;
    test_illegal;
    test_clr_mid_scan;
    test_random_games;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
